// File: rtl/rf_pkg.sv
// Shared types and default sizes for the scoreboarded register file.
package rf_pkg;

    typedef enum logic {
        RF_SWEEP = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;

    localparam int RF_WIDTH = 32;
    localparam int RF_DEPTH = 32;
    localparam int RF_AW    = 5;

endpackage

// File: rtl/register_file_sb_if.sv
// Issue/write-back/read bundle between the pipeline and the register file.
interface register_file_sb_if #(
    parameter int WIDTH    = rf_pkg::RF_WIDTH,
    parameter int AW       = rf_pkg::RF_AW,
    parameter int NUM_READ = 2
);
    logic                      rgWrtEn;
    logic [AW-1:0]             rgWrtDest;
    logic [WIDTH-1:0]          rgWrtData;
    logic                      rgIssueEn;
    logic [AW-1:0]             rgIssueDest;
    logic                      rgFlush;
    logic                      rgClrReq;
    logic [NUM_READ*AW-1:0]    rgRdAddr;
    logic [NUM_READ*WIDTH-1:0] rgRdData;
    logic [NUM_READ-1:0]       rgRdBusy;
    logic                      rgReady;

    modport master (
        output rgWrtEn, rgWrtDest, rgWrtData, rgIssueEn, rgIssueDest,
               rgFlush, rgClrReq, rgRdAddr,
        input  rgRdData, rgRdBusy, rgReady
    );

    modport slave (
        input  rgWrtEn, rgWrtDest, rgWrtData, rgIssueEn, rgIssueDest,
               rgFlush, rgClrReq, rgRdAddr,
        output rgRdData, rgRdBusy, rgReady
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for hazard detection: clear-all > issue > flush > write-back.
module rf_scoreboard #(
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int NUM_READ = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clr_all,
    input  logic                   i_issue_en,
    input  logic [AW-1:0]          i_issue_dest,
    input  logic                   i_wr_en,
    input  logic [AW-1:0]          i_wr_dest,
    input  logic                   i_flush,
    input  logic [NUM_READ*AW-1:0] i_rd_addr,
    output logic [NUM_READ-1:0]    o_rd_busy
);

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_next;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_bit
            if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
                assign w_busy_next[gi] = 1'b0;
            end else begin : g_norm
                localparam logic [AW-1:0] L_IDX = AW'(gi);
                // A same-cycle issue is the newer producer, so it outranks flush and write-back.
                assign w_busy_next[gi] = i_clr_all                                ? 1'b0 :
                                         (i_issue_en && (i_issue_dest == L_IDX)) ? 1'b1 :
                                         i_flush                                  ? 1'b0 :
                                         (i_wr_en && (i_wr_dest == L_IDX))       ? 1'b0 :
                                                                                    r_busy[gi];
            end
        end

        for (gi = 0; gi < NUM_READ; gi++) begin : g_rd
            assign o_rd_busy[gi] = r_busy[i_rd_addr[gi*AW +: AW]];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

endmodule

// File: rtl/register_file_sb.sv
// Multi-read register file with zero register, write bypass, busy scoreboard
// and a zeroing sweep that runs after reset or on request.
module register_file_sb
    import rf_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int DEPTH    = RF_DEPTH,
    parameter int AW       = RF_AW,
    parameter int NUM_READ = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    register_file_sb_if.slave        bus
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    rf_state_t        r_state;
    rf_state_t        w_state_next;
    logic [AW-1:0]    r_cnt;
    logic [AW-1:0]    w_cnt_next;

    logic             w_ready;
    logic             w_sweep;
    logic             w_clr_busy;
    logic             w_wr_ok;
    logic             w_issue_ok;
    logic             w_flush_ok;

    logic             w_mem_we;
    logic [AW-1:0]    w_mem_waddr;
    logic [WIDTH-1:0] w_mem_wdata;

    logic [NUM_READ-1:0]       w_sb_busy;
    logic [NUM_READ*WIDTH-1:0] w_rd_data;
    logic [NUM_READ-1:0]       w_rd_busy;

    function automatic logic f_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RF_SWEEP;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            RF_SWEEP: begin
                w_cnt_next = r_cnt + AW'(1);
                if (r_cnt == AW'(DEPTH - 1)) begin
                    w_state_next = RF_READY;
                end
            end
            RF_READY: begin
                if (bus.rgClrReq) begin
                    w_state_next = RF_SWEEP;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = RF_SWEEP;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        w_ready    = (r_state == RF_READY);
        w_sweep    = (r_state == RF_SWEEP);
        w_clr_busy = w_ready && bus.rgClrReq;
        w_wr_ok    = w_ready && bus.rgWrtEn   && !f_zero(bus.rgWrtDest);
        w_issue_ok = w_ready && bus.rgIssueEn && !f_zero(bus.rgIssueDest);
        w_flush_ok = w_ready && bus.rgFlush;
    end

    // The sweep owns the single write port while it runs.
    assign w_mem_we    = w_sweep || w_wr_ok;
    assign w_mem_waddr = w_sweep ? r_cnt : bus.rgWrtDest;
    assign w_mem_wdata = w_sweep ? '0    : bus.rgWrtData;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    rf_scoreboard #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .NUM_READ (NUM_READ),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk          (clk),
        .rst          (rst),
        .i_clr_all    (w_clr_busy),
        .i_issue_en   (w_issue_ok),
        .i_issue_dest (bus.rgIssueDest),
        .i_wr_en      (w_wr_ok),
        .i_wr_dest    (bus.rgWrtDest),
        .i_flush      (w_flush_ok),
        .i_rd_addr    (bus.rgRdAddr),
        .o_rd_busy    (w_sb_busy)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_READ; gi++) begin : g_rd
            logic [AW-1:0] w_addr;
            logic          w_hit;
            logic          w_mask;

            assign w_addr = bus.rgRdAddr[gi*AW +: AW];
            assign w_mask = !w_ready || f_zero(w_addr);
            assign w_hit  = (BYPASS != 0) && w_wr_ok && (bus.rgWrtDest == w_addr);

            assign w_rd_data[gi*WIDTH +: WIDTH] = w_mask ? '0 :
                                                  w_hit  ? bus.rgWrtData :
                                                           r_mem[w_addr];
            // Forwarded data is only stale again if the same register is re-issued this cycle.
            assign w_rd_busy[gi] = w_mask ? 1'b0 :
                                   w_hit  ? (w_issue_ok && (bus.rgIssueDest == w_addr)) :
                                            w_sb_busy[gi];
        end
    endgenerate

    assign bus.rgRdData = w_rd_data;
    assign bus.rgRdBusy = w_rd_busy;
    assign bus.rgReady  = w_ready;

endmodule

// File: tb/tb_register_file_sb.sv
// Directed plus random checks of two register files (bypass on / off) against an array model.
module tb_register_file_sb;
    import rf_pkg::*;

    localparam int W  = RF_WIDTH;
    localparam int D  = RF_DEPTH;
    localparam int A  = RF_AW;
    localparam int NR = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    register_file_sb_if #(.WIDTH(W), .AW(A), .NUM_READ(NR)) bus ();
    register_file_sb_if #(.WIDTH(W), .AW(A), .NUM_READ(NR)) bus_nb ();

    assign bus_nb.rgWrtEn     = bus.rgWrtEn;
    assign bus_nb.rgWrtDest   = bus.rgWrtDest;
    assign bus_nb.rgWrtData   = bus.rgWrtData;
    assign bus_nb.rgIssueEn   = bus.rgIssueEn;
    assign bus_nb.rgIssueDest = bus.rgIssueDest;
    assign bus_nb.rgFlush     = bus.rgFlush;
    assign bus_nb.rgClrReq    = bus.rgClrReq;
    assign bus_nb.rgRdAddr    = bus.rgRdAddr;

    register_file_sb #(.WIDTH(W), .DEPTH(D), .AW(A), .NUM_READ(NR), .BYPASS(1), .ZERO_REG(1))
        u_dut (.clk(clk), .rst(rst), .bus(bus.slave));

    register_file_sb #(.WIDTH(W), .DEPTH(D), .AW(A), .NUM_READ(NR), .BYPASS(0), .ZERO_REG(1))
        u_dut_nb (.clk(clk), .rst(rst), .bus(bus_nb.slave));

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: cycles of sweep remaining, register contents, busy flags.
    logic [W-1:0] m_mem [D];
    bit           m_busy [D];
    int           m_left;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < D; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_left = D;
        m_clear();
    endtask

    task automatic model_step();
        int wd;
        int id;
        wd = int'(bus.rgWrtDest);
        id = int'(bus.rgIssueDest);
        if (!rst) begin
            model_reset();
        end else if (m_left > 0) begin
            m_left--;
        end else if (bus.rgClrReq) begin
            m_left = D;
            m_clear();
        end else begin
            if (bus.rgWrtEn && wd != 0) m_mem[wd] = bus.rgWrtData;
            if (bus.rgFlush) begin
                for (int i = 0; i < D; i++) m_busy[i] = 1'b0;
            end
            if (bus.rgWrtEn && wd != 0) m_busy[wd] = 1'b0;
            if (bus.rgIssueEn && id != 0) m_busy[id] = 1'b1;
        end
    endtask

    function automatic logic [31:0] exp_data(input bit byp, input int a);
        if (m_left != 0 || a == 0) return '0;
        if (byp && bus.rgWrtEn && int'(bus.rgWrtDest) == a) return bus.rgWrtData;
        return m_mem[a];
    endfunction

    function automatic logic [31:0] exp_busy(input bit byp, input int a);
        if (m_left != 0 || a == 0) return '0;
        if (byp && bus.rgWrtEn && int'(bus.rgWrtDest) == a)
            return 32'(bus.rgIssueEn && int'(bus.rgIssueDest) == a);
        return 32'(m_busy[a]);
    endfunction

    task automatic check_outputs();
        int a;
        chk("ready",    32'(bus.rgReady),    32'(m_left == 0));
        chk("ready_nb", 32'(bus_nb.rgReady), 32'(m_left == 0));
        for (int p = 0; p < NR; p++) begin
            a = int'(bus.rgRdAddr[p*A +: A]);
            chk($sformatf("p%0d_data_a%0d", p, a),    bus.rgRdData[p*W +: W],     exp_data(1'b1, a));
            chk($sformatf("p%0d_busy_a%0d", p, a),    32'(bus.rgRdBusy[p]),       exp_busy(1'b1, a));
            chk($sformatf("nb_p%0d_data_a%0d", p, a), bus_nb.rgRdData[p*W +: W],  exp_data(1'b0, a));
            chk($sformatf("nb_p%0d_busy_a%0d", p, a), 32'(bus_nb.rgRdBusy[p]),    exp_busy(1'b0, a));
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic at_pos();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cycle();
        at_neg();
        at_pos();
    endtask

    task automatic set_idle();
        bus.rgWrtEn     = 1'b0;
        bus.rgWrtDest   = '0;
        bus.rgWrtData   = '0;
        bus.rgIssueEn   = 1'b0;
        bus.rgIssueDest = '0;
        bus.rgFlush     = 1'b0;
        bus.rgClrReq    = 1'b0;
    endtask

    task automatic rd(input int a0, input int a1);
        bus.rgRdAddr = {A'(a1), A'(a0)};
    endtask

    task automatic wr(input int dest, input logic [31:0] data);
        bus.rgWrtEn   = 1'b1;
        bus.rgWrtDest = A'(dest);
        bus.rgWrtData = data;
    endtask

    task automatic issue(input int dest);
        bus.rgIssueEn   = 1'b1;
        bus.rgIssueDest = A'(dest);
    endtask

    task automatic wait_ready(output int n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            cycle();
            if (bus.rgReady === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0;
        set_idle();
        rd(0, 0);
        model_reset();
        repeat (3) cycle();

        // Power-up sweep, then every register reads zero.
        rst = 1'b1;
        wait_ready(n);
        chk("ready_latency", 32'(n), 32'd32);
        for (int a = 0; a < D; a += 2) begin
            rd(a, a + 1);
            cycle();
        end

        // Bypass versus no-bypass read-during-write.
        wr(5, 32'hDEADBEEF);
        rd(5, 5);
        at_neg();
        chk("byp_same_cycle",   bus.rgRdData[0 +: W],    32'hDEADBEEF);
        chk("nobyp_same_cycle", bus_nb.rgRdData[0 +: W], 32'h0);
        at_pos();
        set_idle();
        at_neg();
        chk("nobyp_next_cycle", bus_nb.rgRdData[0 +: W], 32'hDEADBEEF);
        at_pos();

        // Register 0 ignores writes and issues.
        wr(0, 32'h12345678);
        issue(0);
        rd(0, 0);
        cycle();
        set_idle();
        at_neg();
        chk("reg0_data_p0", bus.rgRdData[0 +: W], 32'h0);
        chk("reg0_data_p1", bus.rgRdData[W +: W], 32'h0);
        chk("reg0_busy",    32'(bus.rgRdBusy),    32'h0);
        at_pos();

        // Issue then write-back; issue and write to the same register together.
        issue(7);
        rd(0, 7);
        cycle();
        set_idle();
        at_neg();
        chk("busy7_set", 32'(bus.rgRdBusy[1]), 32'd1);
        at_pos();
        wr(7, 32'h00000077);
        at_neg();
        chk("busy7_bypass",   32'(bus.rgRdBusy[1]),    32'd0);
        chk("busy7_nobypass", 32'(bus_nb.rgRdBusy[1]), 32'd1);
        at_pos();
        set_idle();
        at_neg();
        chk("busy7_cleared", 32'(bus.rgRdBusy[1]), 32'd0);
        at_pos();
        wr(9, 32'hCAFE0009);
        issue(9);
        rd(9, 9);
        cycle();
        set_idle();
        at_neg();
        chk("reg9_data",    bus.rgRdData[0 +: W], 32'hCAFE0009);
        chk("reg9_busy_p0", 32'(bus.rgRdBusy[0]), 32'd1);
        chk("reg9_busy_p1", 32'(bus.rgRdBusy[1]), 32'd1);
        at_pos();

        // Flush with a simultaneous issue.
        issue(3);
        cycle();
        issue(4);
        cycle();
        set_idle();
        bus.rgFlush = 1'b1;
        issue(6);
        cycle();
        set_idle();
        rd(3, 4);
        at_neg();
        chk("flush_busy3", 32'(bus.rgRdBusy[0]), 32'd0);
        chk("flush_busy4", 32'(bus.rgRdBusy[1]), 32'd0);
        at_pos();
        rd(6, 6);
        at_neg();
        chk("flush_busy6", 32'(bus.rgRdBusy[0]), 32'd1);
        at_pos();

        // Clear request: sweep ignores writes, then register 10 reads zero.
        wr(10, 32'hA5A5A5A5);
        cycle();
        set_idle();
        bus.rgClrReq = 1'b1;
        cycle();
        bus.rgClrReq = 1'b0;
        rd(10, 10);
        for (int i = 1; i <= D; i++) begin
            wr(10, $urandom);
            issue(10);
            at_neg();
            chk($sformatf("sweep_ready_low_c%0d", i), 32'(bus.rgReady), 32'd0);
            at_pos();
        end
        set_idle();
        at_neg();
        chk("after_clr_ready", 32'(bus.rgReady),    32'd1);
        chk("after_clr_reg10", bus.rgRdData[0 +: W], 32'h0);
        at_pos();

        // Reset in the middle of a sweep restarts it from the beginning.
        bus.rgClrReq = 1'b1;
        cycle();
        bus.rgClrReq = 1'b0;
        repeat (10) cycle();
        rst = 1'b0;
        #1;
        model_reset();
        chk("async_rst_ready", 32'(bus.rgReady), 32'd0);
        cycle();
        rst = 1'b1;
        wait_ready(n);
        chk("rst_midsweep_latency", 32'(n), 32'd32);

        // Random traffic concentrated on a few registers to provoke collisions.
        for (int c = 0; c < 600; c++) begin
            set_idle();
            if ($urandom_range(0, 1) == 1) wr($urandom_range(0, 11), $urandom);
            if ($urandom_range(0, 2) == 0) issue($urandom_range(0, 11));
            bus.rgFlush  = ($urandom_range(0, 15) == 0);
            bus.rgClrReq = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 3) == 0) begin
                n = $urandom_range(0, 11);
                rd(n, n);
            end else begin
                rd($urandom_range(0, 11), $urandom_range(0, D - 1));
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Parametrised successor to the single-write/dual-read register file for the RISC-V core.
- Adds a configurable number of read ports, a hardwired zero register, optional write-to-read bypass, a per-register busy scoreboard for pipeline hazard detection, and a zeroing sweep FSM that runs after reset or on request.
- Sits between decode/issue (reads, issue marking) and write-back (data write, busy clear).

Parameters:
- WIDTH, 32, data width of each register.
- DEPTH, 32, number of registers; power of two, >= 4.
- AW, 5, address width; must equal log2(DEPTH).
- NUM_READ, 2, number of independent combinational read ports (1..4).
- BYPASS, 1, when 1, a same-cycle write is forwarded to matching read ports.
- ZERO_REG, 1, when 1, register 0 always reads 0, never goes busy, and ignores writes and issues.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- rgWrtEn  input  1  write-back strobe.
- rgWrtDest  input  AW  write-back destination.
- rgWrtData  input  WIDTH  write-back data.
- rgIssueEn  input  1  marks rgIssueDest busy (instruction issued).
- rgIssueDest  input  AW  destination being issued.
- rgFlush  input  1  clears all busy bits (pipeline flush).
- rgClrReq  input  1  starts a zeroing sweep (pulse, sampled in READY only).
- rgRdAddr  input  NUM_READ*AW  packed read addresses; port i at [i*AW +: AW].
- rgRdData  output  NUM_READ*WIDTH  packed read data; port i at [i*WIDTH +: WIDTH].
- rgRdBusy  output  NUM_READ  busy flag per read port.
- rgReady  output  1  high when in READY; low during a sweep.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to SWEEP, sweep counter to 0, all busy bits to 0, rgReady to 0.
  - The storage array is not reset.
- FSM has two states, SWEEP and READY.
- SWEEP:
  - Each cycle writes 0 to reg[cnt], then cnt increments.
  - In the cycle with cnt == DEPTH-1, the last zero is written and state goes to READY.
  - rgReady is registered; it is first seen high DEPTH cycles after the first rising edge with rst=1.
  - rgWrtEn, rgIssueEn, rgFlush and rgClrReq are ignored.
  - rgRdData is forced to 0 and rgRdBusy to 0.
- READY with rgClrReq=1 sampled at an edge: next state is SWEEP, cnt=0, all busy bits cleared, rgReady low the next cycle.
- Write (READY): if rgWrtEn=1 and the destination is not a suppressed reg 0, reg[rgWrtDest] <= rgWrtData and busy[rgWrtDest] <= 0, on the clock edge.
- Issue (READY): if rgIssueEn=1, busy[rgIssueDest] <= 1.
  - Issue and write to the same register in the same cycle: data is written and busy ends at 1 (issue wins).
- Flush: rgFlush=1 clears all busy bits.
  - Same-cycle issue still sets its bit (issue wins over flush).
  - Same-cycle write still writes data.
- Reads are combinational with zero latency.
  - rgRdData[i] = reg[addr_i].
  - rgRdBusy[i] = busy[addr_i].
- Bypass (BYPASS=1, READY, rgWrtEn=1, rgWrtDest == addr_i, not suppressed reg 0):
  - rgRdData[i] = rgWrtData.
  - rgRdBusy[i] = 0, unless rgIssueEn=1 with rgIssueDest == addr_i (then 1).
- BYPASS=0: read-during-write returns the old value and the old busy bit.
- ZERO_REG=1: address 0 always reads data 0 and busy 0, on every port, in every state.
- Multiple read ports may address the same register; each returns identical results.
- Widths: no truncation anywhere.
  - The sweep counter is AW bits wide; its wrap from DEPTH-1 is never used because the state changes.
  - The counter value in READY is don't-care.
- Reset asserted mid-sweep or mid-operation: immediate return to the reset state; the sweep restarts from 0 when reset is released.

Decomposition:
- Shared package rf_pkg holds:
  - the state encoding (RF_SWEEP=1'b0, RF_READY=1'b1);
  - default constants RF_WIDTH=32, RF_DEPTH=32, RF_AW=5.
- One natural sub-module, rf_scoreboard: the DEPTH-bit busy vector with its issue/write/flush priority logic and per-port busy lookup.
- Storage, bypass muxes and the sweep FSM stay in register_file_sb.

Test Plan:
1. Reset, then release with rst=1 -> rgReady=0 for cycles 1..31 and 1 at cycle 32; every address then reads 0x00000000 with busy 0.
2. Write reg5=0xDEADBEEF with port0 addr=5 in the same cycle (BYPASS=1) -> port0 reads 0xDEADBEEF that cycle; with BYPASS=0 it reads 0 that cycle and 0xDEADBEEF the next.
3. Write reg0=0x12345678 and issue reg0 -> reg0 reads 0 with busy 0 on all ports.
4. Issue reg7 -> port1 busy=1; a later write to reg7 -> busy=0. Issue and write reg9 in the same cycle -> data updated, busy stays 1.
5. Issue reg3 and reg4, then rgFlush together with a new issue of reg6 -> busy3=0, busy4=0, busy6=1.
6. Write reg10=0xA5A5A5A5, then pulse rgClrReq -> rgReady low for 32 cycles, writes during that window are ignored, and reg10 reads 0 afterwards. Assert rst mid-sweep -> the sweep restarts and takes a full 32 cycles.
